// File: rtl/next_pc_gen.sv
// Fetch-side next-PC generator with a direct-mapped BTB.
// The gshare direction comes in on branch_predict_i; the BTB target is used when it says taken.
module next_pc_gen #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        btb_update_valid_i,
    input  logic [31:0] btb_update_pc_i,
    input  logic [31:0] btb_update_target_i,
    input  logic        btb_flush_i,
    input  logic        branch_predict_i,
    output logic [31:0] pc_o,
    output logic        fetch_valid_o,
    output logic [9:0]  pc_lsb10_o,
    output logic        branch_predict_valid_o,
    output logic        predicted_taken_o
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    logic [31:0]            pc_q, pc_d;
    logic                   fetch_valid_q;
    logic [BTB_ENTRIES-1:0] valid_q, valid_d;

    // Tag/target storage is never reset; only the valid bits gate a hit.
    logic [TAG_W-1:0] tag_mem [BTB_ENTRIES];
    logic [29:0]      tgt_mem [BTB_ENTRIES];

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             hit;
    logic [IDX-1:0]   upd_idx;
    logic             unused_lsbs;

    assign lk_idx  = pc_q[IDX+1:2];
    assign lk_tag  = pc_q[31:IDX+2];
    assign hit     = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign upd_idx = btb_update_pc_i[IDX+1:2];

    assign unused_lsbs = ^{redirect_pc_i[1:0], btb_update_pc_i[1:0], btb_update_target_i[1:0]};

    assign pc_o                   = pc_q;
    assign fetch_valid_o          = fetch_valid_q;
    assign pc_lsb10_o             = pc_q[11:2];
    assign branch_predict_valid_o = hit & fetch_valid_q;
    assign predicted_taken_o      = branch_predict_valid_o & branch_predict_i;

    // The first edge after reset only raises fetch_valid, so RESET_PC is fetched once.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (redirect_valid_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
        end else if (stall_i || !fetch_valid_q) begin
            pc_d = pc_q;
        end else if (predicted_taken_o) begin
            pc_d = {tgt_mem[lk_idx], 2'b00};
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (btb_flush_i) begin
            valid_d = '0;
        end else if (btb_update_valid_i) begin
            valid_d[upd_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            valid_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_valid_q <= 1'b1;
            valid_q       <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (btb_update_valid_i) begin
            tag_mem[upd_idx] <= btb_update_pc_i[31:IDX+2];
            tgt_mem[upd_idx] <= btb_update_target_i[31:2];
        end
    end

endmodule
